// File: rtl/lcv_dot_prod_seq.sv
`default_nettype none
// ============================================================================
//  Module   : lcv_dot_prod_seq
//  Purpose  : Sequencer and accumulator for signed 16x16 dot products over a
//             streamed vector. A start command loads the vector length and a
//             33-bit bias. One operand pair is consumed per handshake, and each
//             product is added into a 33-bit wrapping accumulator with a sticky
//             overflow flag. The final sum is presented on a valid/ready port.
//  Ports    : clk, rst             - clock, synchronous active-high reset
//             start, len, bias     - command (honoured only while idle)
//             in_valid/in_ready    - operand stream handshake
//             in_a, in_b           - signed 16-bit operands
//             out_valid/out_ready  - result handshake
//             out_sum, out_ovf     - 33-bit result and sticky overflow
//             busy                 - high whenever not idle
//  Revision : 1.0 - initial release
// ============================================================================
module lcv_dot_prod_seq #(
    parameter int LEN_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [LEN_WIDTH-1:0] len,
    input  logic signed [32:0]   bias,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic signed [15:0]   in_a,
    input  logic signed [15:0]   in_b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic signed [32:0]   out_sum,
    output logic                 out_ovf,
    output logic                 busy
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic signed [32:0]     acc_q,   acc_d;
    logic [LEN_WIDTH-1:0]   cnt_q,   cnt_d;
    logic                   ovf_q,   ovf_d;

    logic signed [31:0]     prod_w;
    logic signed [33:0]     sum_w;
    logic                   sum_oor_w;
    logic                   in_fire_w;

    // Both operands are widened before the multiply so the product is exact.
    assign prod_w    = 32'(in_a) * 32'(in_b);
    assign sum_w     = 34'(acc_q) + 34'(prod_w);
    // The 34-bit sum fits in 33 signed bits only when its top two bits agree.
    assign sum_oor_w = sum_w[33] ^ sum_w[32];

    assign in_fire_w = (state_q == ST_RUN) && in_valid;

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    acc_d   = bias;
                    cnt_d   = len;
                    ovf_d   = 1'b0;
                    state_d = (len == '0) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                if (in_fire_w) begin
                    acc_d = sum_w[32:0];
                    cnt_d = cnt_q - LEN_WIDTH'(1);
                    ovf_d = ovf_q | sum_oor_w;
                    if (cnt_q == LEN_WIDTH'(1)) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
        end
    end

    // Handshake outputs decode registered state only; no path from inputs.
    assign in_ready  = (state_q == ST_RUN);
    assign out_valid = (state_q == ST_DONE);
    assign busy      = (state_q != ST_IDLE);
    assign out_sum   = acc_q;
    assign out_ovf   = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_lcv_dot_prod_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_lcv_dot_prod_seq
//  Purpose  : Directed self-checking bench for lcv_dot_prod_seq with
//             hand-computed expected sums and handshake timing.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_lcv_dot_prod_seq;

    logic                clk;
    logic                rst;
    logic                start;
    logic [7:0]          len;
    logic signed [32:0]  bias;
    logic                in_valid;
    logic                in_ready;
    logic signed [15:0]  in_a;
    logic signed [15:0]  in_b;
    logic                out_valid;
    logic                out_ready;
    logic signed [32:0]  out_sum;
    logic                out_ovf;
    logic                busy;

    int n_vec;
    int n_err;

    lcv_dot_prod_seq #(.LEN_WIDTH(8)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .len       (len),
        .bias      (bias),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_ovf   (out_ovf),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic signed [63:0] got,
                             input logic signed [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance to 1 ns after the next rising edge; all driving and sampling
    // happens at that point, well away from the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_cmd(input logic [7:0] l, input logic signed [32:0] b);
        start = 1'b1;
        len   = l;
        bias  = b;
        step();
        start = 1'b0;
    endtask

    task automatic feed(input logic signed [15:0] a, input logic signed [15:0] b);
        check_val("feed_in_ready", in_ready, 1);
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        step();
        in_valid = 1'b0;
    endtask

    task automatic take_result();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check_val("post_hs_valid", out_valid, 0);
        check_val("post_hs_busy",  busy,      0);
    endtask

    initial begin
        n_vec     = 0;
        n_err     = 0;
        rst       = 1'b1;
        start     = 1'b0;
        len       = '0;
        bias      = '0;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        out_ready = 1'b0;
        step();
        step();
        check_val("rst_in_ready",  in_ready,  0);
        check_val("rst_out_valid", out_valid, 0);
        check_val("rst_busy",      busy,      0);
        check_val("rst_out_sum",   out_sum,   0);
        check_val("rst_out_ovf",   out_ovf,   0);
        rst = 1'b0;
        step();

        // Three pairs back to back: 6 - 20 + 10000 = 9986.
        start_cmd(8'd3, 33'sd0);
        check_val("t1_busy",     busy,     1);
        check_val("t1_in_ready", in_ready, 1);
        feed(16'sd2, 16'sd3);
        check_val("t1_mid_valid", out_valid, 0);
        feed(-16'sd4, 16'sd5);
        feed(16'sd100, 16'sd100);
        check_val("t1_out_valid", out_valid, 1);
        check_val("t1_in_ready0", in_ready,  0);
        check_val("t1_sum",       out_sum,   9986);
        check_val("t1_ovf",       out_ovf,   0);
        take_result();

        // Zero-length command goes straight to a result of bias.
        start_cmd(8'd0, -33'sd7);
        check_val("t2_out_valid", out_valid, 1);
        check_val("t2_in_ready",  in_ready,  0);
        check_val("t2_sum",       out_sum,   -7);
        check_val("t2_ovf",       out_ovf,   0);
        take_result();

        // Wrap: (2^32-1)+1 -> -2^32 with ovf, then +2^30 -> -3221225472.
        start_cmd(8'd2, 33'sd4294967295);
        feed(16'sd1, 16'sd1);
        feed(-16'sd32768, -16'sd32768);
        check_val("t3_out_valid", out_valid, 1);
        check_val("t3_sum",       out_sum,   -64'sd3221225472);
        check_val("t3_ovf",       out_ovf,   1);
        take_result();

        // Bubbles on input, stalled output, starts ignored: 5+2+12+30+56=105.
        start_cmd(8'd4, 33'sd5);
        feed(16'sd1, 16'sd2);
        step();
        check_val("t4_bubble_valid", out_valid, 0);
        feed(16'sd3, 16'sd4);
        step();
        feed(16'sd5, 16'sd6);
        step();
        check_val("t4_bubble_valid2", out_valid, 0);
        feed(16'sd7, 16'sd8);
        start = 1'b1;
        len   = 8'd1;
        bias  = 33'sd999;
        for (int i = 0; i < 5; i++) begin
            check_val("t4_hold_valid", out_valid, 1);
            check_val("t4_hold_sum",   out_sum,   105);
            check_val("t4_hold_ovf",   out_ovf,   0);
            step();
        end
        // start stays high through the handshake edge and must be ignored.
        take_result();
        start = 1'b0;
        check_val("t4_idle_ready", in_ready, 0);
        step();
        check_val("t4_still_idle", busy, 0);

        // Reset after two of four pairs: pending result is discarded.
        start_cmd(8'd4, 33'sd0);
        feed(16'sd9, 16'sd9);
        feed(16'sd9, 16'sd9);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_val("t5_in_ready", in_ready, 0);
        check_val("t5_busy",     busy,     0);
        for (int i = 0; i < 4; i++) begin
            check_val("t5_no_valid", out_valid, 0);
            step();
        end
        start_cmd(8'd1, 33'sd10);
        feed(16'sd3, -16'sd3);
        check_val("t5_out_valid", out_valid, 1);
        check_val("t5_sum",       out_sum,   1);
        check_val("t5_ovf",       out_ovf,   0);
        take_result();

        // Back-to-back: first run overflows (-2^32 - 1 wraps to 2^32-1),
        // second run starts on the first idle cycle: 3 + 4 - 5 = 2, ovf clear.
        start_cmd(8'd1, -33'sd4294967296);
        feed(-16'sd1, 16'sd1);
        check_val("t6a_sum", out_sum, 64'sd4294967295);
        check_val("t6a_ovf", out_ovf, 1);
        take_result();
        start_cmd(8'd2, 33'sd3);
        check_val("t6b_in_ready", in_ready, 1);
        feed(16'sd2, 16'sd2);
        feed(-16'sd1, 16'sd5);
        check_val("t6b_out_valid", out_valid, 1);
        check_val("t6b_sum",       out_sum,   2);
        check_val("t6b_ovf",       out_ovf,   0);
        take_result();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
